// File: rtl/proximity_guard.sv
// Viewing-distance guard: pings the ultrasonic front end, debounces near/far samples and blanks the screen.
// Latency: sample -> confirm counters +1 cycle, -> state/blank +1 cycle; led updates 1 cycle after a sample.
// Backpressure: none, every strobe is consumed on arrival. Optional watchdog macro: PROXIMITY_GUARD_FAILSAFE_EN.
module proximity_guard #(
    parameter int CLK_MHZ        = 50,
    parameter int PERIOD_PING_MS = 60,
    parameter int DIST_W         = 21,
    parameter int UNITS_PER_CM   = 2900,
    parameter int NEAR_CM        = 50,
    parameter int FAR_CM         = 60,
    parameter int CONFIRM_N      = 3,
    parameter int HOLD_MS        = 10000,
    parameter int RELEASE_MS     = 2000,
    parameter int LED_N          = 8,
    parameter int LED_STEP_CM    = 5
) (
    input  logic              clk,
    input  logic              reset,
    output logic              start,
    input  logic              new_measure,
    input  logic              timeout,
    input  logic [DIST_W-1:0] distance_raw,
    output logic              blank,
    output logic [1:0]        state,
    output logic [LED_N-1:0]  led,
    output logic              fault
);

    localparam int MS_CYC   = CLK_MHZ * 1000;
    localparam int PING_CYC = PERIOD_PING_MS * MS_CYC;
    localparam int PRE_W    = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int PING_W   = (PING_CYC > 1) ? $clog2(PING_CYC) : 1;
    localparam int MAX_MS   = (HOLD_MS > RELEASE_MS) ? HOLD_MS : RELEASE_MS;
    localparam int MS_W     = $clog2(MAX_MS + 1);
    localparam int CNT_W    = $clog2(CONFIRM_N + 1);

    localparam logic [PING_W-1:0] PING_LAST = PING_W'(PING_CYC - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(MS_CYC - 1);
    localparam logic [MS_W-1:0]   MS_MAX    = MS_W'(MAX_MS);
    localparam logic [MS_W-1:0]   HOLD_LIM  = MS_W'(HOLD_MS);
    localparam logic [MS_W-1:0]   REL_LIM   = MS_W'(RELEASE_MS);
    localparam logic [CNT_W-1:0]  CONF      = CNT_W'(CONFIRM_N);

    // One spare bit so the threshold products cannot alias against a full-scale distance.
    localparam logic [DIST_W:0] NEAR_TH = (DIST_W+1)'(NEAR_CM * UNITS_PER_CM);
    localparam logic [DIST_W:0] FAR_TH  = (DIST_W+1)'(FAR_CM * UNITS_PER_CM);

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        PENDING   = 2'd1,
        BLANKED   = 2'd2,
        RELEASING = 2'd3
    } state_e;

    function automatic logic [DIST_W:0] led_th(input int idx);
        led_th = (DIST_W+1)'((idx + 1) * LED_STEP_CM * UNITS_PER_CM);
    endfunction

    logic [PING_W-1:0] ping_cnt_q, ping_cnt_d;
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]  near_cnt_q, near_cnt_d;
    logic [CNT_W-1:0]  far_cnt_q, far_cnt_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [MS_W-1:0]   ms_inc;
    state_e            state_q, state_d;
    logic              blank_q, blank_d;
    logic [LED_N-1:0]  led_q, led_d;

    logic              ms_tick;
    logic              sample_vld;
    logic              smp_near;
    logic              smp_far;
    logic              near_ok;
    logic              far_ok;
    logic              force_blank;
    logic [DIST_W:0]   dist_ext;

    assign dist_ext   = {1'b0, distance_raw};
    assign ms_tick    = (pre_cnt_q == PRE_LAST);
    assign sample_vld = new_measure | timeout;
    // A timeout means no echo at all, so it is far whatever distance_raw holds.
    assign smp_far    = timeout | (dist_ext >= FAR_TH);
    assign smp_near   = ~timeout & (dist_ext < NEAR_TH);
    assign near_ok    = (near_cnt_q == CONF);
    assign far_ok     = (far_cnt_q == CONF);

    assign start = (ping_cnt_q == PING_LAST);
    assign blank = blank_q;
    assign state = state_q;
    assign led   = led_q;

    // Free-running ping period counter and millisecond prescaler.
    always_comb begin
        ping_cnt_d = (ping_cnt_q == PING_LAST) ? '0 : ping_cnt_q + 1'b1;
        pre_cnt_d  = ms_tick ? '0 : pre_cnt_q + 1'b1;
    end

    // Saturating consecutive-sample counters; a band sample breaks both runs.
    always_comb begin
        near_cnt_d = near_cnt_q;
        far_cnt_d  = far_cnt_q;
        if (sample_vld) begin
            if (smp_far) begin
                far_cnt_d  = far_ok ? far_cnt_q : far_cnt_q + 1'b1;
                near_cnt_d = '0;
            end else if (smp_near) begin
                near_cnt_d = near_ok ? near_cnt_q : near_cnt_q + 1'b1;
                far_cnt_d  = '0;
            end else begin
                near_cnt_d = '0;
                far_cnt_d  = '0;
            end
        end
    end

    // Bar graph follows each echo; a missing echo lights every segment.
    always_comb begin
        led_d = led_q;
        if (timeout) begin
            led_d = '1;
        end else if (new_measure) begin
            for (int i = 0; i < LED_N; i++) begin
                led_d[i] = (dist_ext > led_th(i));
            end
        end
    end

    // Hold/release state machine; limits are checked on the registered ms count.
    always_comb begin
        state_d = state_q;
        ms_inc  = (ms_tick && (ms_cnt_q < MS_MAX)) ? ms_cnt_q + 1'b1 : ms_cnt_q;
        ms_cnt_d = ms_cnt_q;
        case (state_q)
            CLEAR: begin
                if (near_ok) begin
                    state_d  = PENDING;
                    ms_cnt_d = '0;
                end
            end
            PENDING: begin
                ms_cnt_d = ms_inc;
                if (far_ok) begin
                    state_d = CLEAR;
                end else if (ms_cnt_q >= HOLD_LIM) begin
                    state_d = BLANKED;
                end
            end
            BLANKED: begin
                if (far_ok) begin
                    state_d  = RELEASING;
                    ms_cnt_d = '0;
                end
            end
            RELEASING: begin
                ms_cnt_d = ms_inc;
                // A returning viewer beats the release timer: fail toward blanking.
                if (near_ok) begin
                    state_d = BLANKED;
                end else if (ms_cnt_q >= REL_LIM) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d  = CLEAR;
                ms_cnt_d = '0;
            end
        endcase
        if (force_blank) begin
            state_d = BLANKED;
        end
        blank_d = (state_d == BLANKED) || (state_d == RELEASING);
    end

    // Core state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ping_cnt_q <= '0;
            pre_cnt_q  <= '0;
            near_cnt_q <= '0;
            far_cnt_q  <= '0;
            ms_cnt_q   <= '0;
            state_q    <= CLEAR;
            blank_q    <= 1'b0;
            led_q      <= '0;
        end else begin
            ping_cnt_q <= ping_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            near_cnt_q <= near_cnt_d;
            far_cnt_q  <= far_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            state_q    <= state_d;
            blank_q    <= blank_d;
            led_q      <= led_d;
        end
    end

`ifdef PROXIMITY_GUARD_FAILSAFE_EN
    localparam int WD_LIM = 4 * PERIOD_PING_MS;
    localparam int WD_W   = $clog2(WD_LIM + 1);
    localparam logic [WD_W-1:0] WD_END = WD_W'(WD_LIM);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            fault_q, fault_d;

    // Sensor-silence watchdog: any sample rearms it and clears the fault.
    always_comb begin
        wd_cnt_d    = wd_cnt_q;
        fault_d     = fault_q;
        force_blank = 1'b0;
        if (sample_vld) begin
            wd_cnt_d = '0;
            fault_d  = 1'b0;
        end else begin
            if (ms_tick && (wd_cnt_q != WD_END)) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
            if (wd_cnt_q == WD_END) begin
                fault_d     = 1'b1;
                force_blank = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            fault_q  <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign force_blank = 1'b0;
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_proximity_guard.sv
// Scoreboard bench for proximity_guard with 1 ms ping/tick periods of 1000 cycles.
// Expected start cycles, state transitions and led values are queued by the stimulus.
// A negedge monitor pops and compares whenever the DUT presents start, a state change, or a sample result.
module tb_proximity_guard;

    localparam int NEAR_RAW = 29000;   // 10 cm
    localparam int MID_RAW  = 43500;   // 15 cm, exactly on the third LED threshold
    localparam int BAND_RAW = 159500;  // 55 cm
    localparam int NEAR_TH  = 145000;  // 50 cm, first non-near value
    localparam int FAR_LO   = 173999;  // just under 60 cm, still band
    localparam int FAR_TH   = 174000;  // 60 cm, first far value

    typedef struct {
        int cyc;
        int st;
        int bl;
    } tr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start;
    logic        new_measure = 1'b0;
    logic        timeout = 1'b0;
    logic [20:0] distance_raw = '0;
    logic        blank;
    logic [1:0]  state;
    logic [7:0]  led;
    logic        fault;

    int   cyc;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    int   start_q[$];
    tr_t  tr_q[$];
    int   led_q[$];

    proximity_guard #(
        .CLK_MHZ(1), .PERIOD_PING_MS(1), .DIST_W(21), .UNITS_PER_CM(2900),
        .NEAR_CM(50), .FAR_CM(60), .CONFIRM_N(3), .HOLD_MS(20), .RELEASE_MS(5),
        .LED_N(8), .LED_STEP_CM(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .new_measure(new_measure),
        .timeout(timeout), .distance_raw(distance_raw), .blank(blank),
        .state(state), .led(led), .fault(fault)
    );

    always #5 clk = ~clk;

    // Cycle index equals the DUT ping counter value while reset is released.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // One-cycle sample strobe in cycle c; the led result is queued for the monitor.
    task automatic do_sample(input int c, input logic nm, input logic to, input int d, input int exp_led);
        wait_cyc(c);
        #1;
        new_measure  = nm;
        timeout      = to;
        distance_raw = 21'(d);
        led_q.push_back(exp_led);
        @(negedge clk);
        #1;
        new_measure = 1'b0;
        timeout     = 1'b0;
    endtask

    task automatic expect_tr(input int c, input int st, input int bl);
        tr_t t;
        t.cyc = c;
        t.st  = st;
        t.bl  = bl;
        tr_q.push_back(t);
    endtask

    // Monitor: compares DUT-presented events against the scoreboard queues.
    initial begin
        int  prev_st;
        int  prev_bl;
        tr_t t;
        prev_st = 0;
        prev_bl = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (start === 1'b1) begin
                    if (start_q.size() == 0) check("start_unexpected", cyc, -1);
                    else check("start_cycle", cyc, start_q.pop_front());
                end
                if (new_measure || timeout) begin
                    if (led_q.size() == 0) check("led_unexpected", led, -1);
                    else check("led_value", led, led_q.pop_front());
                end
                if ((int'(state) != prev_st) || (int'(blank) != prev_bl)) begin
                    if (tr_q.size() == 0) begin
                        check("state_unexpected", state, prev_st);
                    end else begin
                        t = tr_q.pop_front();
                        check("trans_cycle", cyc, t.cyc);
                        check("trans_state", state, t.st);
                        check("trans_blank", blank, t.bl);
                    end
                    prev_st = int'(state);
                    prev_bl = int'(blank);
                end
            end
        end
    end

    initial begin
        int reset_cyc;
`ifdef PROXIMITY_GUARD_FAILSAFE_EN
        reset_cyc = 4500;
`else
        reset_cyc = 51500;
`endif
        for (int k = 0; (k * 1000 + 999) < reset_cyc; k++) start_q.push_back(k * 1000 + 999);

        #3;
        check("rst_start", start, 0);
        check("rst_blank", blank, 0);
        check("rst_state", state, 0);
        check("rst_led", led, 0);
        check("rst_fault", fault, 0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

`ifdef PROXIMITY_GUARD_FAILSAFE_EN
        // Silent sensor: four ms ticks without a sample forces blanking.
        expect_tr(4001, 2, 1);
        wait_cyc(3990);
        check("fs_fault_early", fault, 0);
        wait_cyc(4100);
        check("fs_fault_set", fault, 1);
        check("fs_blank_set", blank, 1);
        do_sample(4200, 1'b0, 1'b1, 0, 8'hFF);
        wait_cyc(4202);
        check("fs_fault_clear", fault, 0);
        check("fs_blank_held", blank, 1);
`else
        // Hold: three near samples, then 20 ms in PENDING.
        do_sample(100, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        do_sample(200, 1'b1, 1'b0, MID_RAW, 8'h03);
        expect_tr(302, 1, 0);
        expect_tr(20001, 2, 1);
        do_sample(300, 1'b1, 1'b0, NEAR_RAW, 8'h01);

        // Hysteresis band keeps BLANKED; three timeouts release after 5 ms.
        do_sample(20100, 1'b1, 1'b0, BAND_RAW, 8'hFF);
        do_sample(20200, 1'b1, 1'b0, BAND_RAW, 8'hFF);
        do_sample(20300, 1'b1, 1'b0, BAND_RAW, 8'hFF);
        do_sample(20400, 1'b1, 1'b0, FAR_LO, 8'hFF);
        do_sample(20500, 1'b0, 1'b1, 0, 8'hFF);
        do_sample(20600, 1'b0, 1'b1, 0, 8'hFF);
        expect_tr(20702, 3, 1);
        expect_tr(25001, 0, 0);
        do_sample(20700, 1'b0, 1'b1, 0, 8'hFF);
        wait_cyc(25010);
        check("released_led", led, 8'hFF);

        // Debounce: a band sample (exactly 50 cm) breaks the near run.
        do_sample(25100, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        do_sample(25200, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        do_sample(25300, 1'b1, 1'b0, NEAR_TH, 8'hFF);
        do_sample(25400, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        do_sample(25500, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        do_sample(25600, 1'b1, 1'b0, BAND_RAW, 8'hFF);
        do_sample(25700, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        do_sample(25800, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        do_sample(25900, 1'b1, 1'b0, FAR_TH, 8'hFF);
        do_sample(26000, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        do_sample(26100, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        expect_tr(26202, 1, 0);
        expect_tr(46001, 2, 1);
        do_sample(26200, 1'b1, 1'b0, NEAR_RAW, 8'h01);

        // Race: third near lands on the tick that completes RELEASE_MS.
        do_sample(46100, 1'b0, 1'b1, 0, 8'hFF);
        do_sample(46200, 1'b0, 1'b1, 0, 8'hFF);
        expect_tr(46302, 3, 1);
        do_sample(46300, 1'b1, 1'b1, NEAR_RAW, 8'hFF);
        do_sample(48999, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        do_sample(49999, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        expect_tr(51001, 2, 1);
        do_sample(50999, 1'b1, 1'b0, NEAR_RAW, 8'h01);
        check("fault_tied", fault, 0);
`endif

        // Asynchronous reset while BLANKED, checked before any clock edge.
        wait_cyc(reset_cyc);
        check("pre_reset_blank", blank, 1);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_blank", blank, 0);
        check("async_state", state, 0);
        check("async_led", led, 0);
        check("async_fault", fault, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_state", state, 0);
        check("post_reset_cyc_restart", cyc, 20);

        check("start_q_drained", start_q.size(), 0);
        check("tr_q_drained", tr_q.size(), 0);
        check("led_q_drained", led_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/proximity_guard.md
Name: proximity_guard

Overview:
- Parametrised successor to the fixed 50 cm / 10 s viewing-distance guard.
- Issues periodic ping strobes to the ultrasonic front end and consumes its measurements (distance_raw, new_measure, timeout).
- Debounces near/far decisions with hysteresis and runs a hold/release state machine that drives `blank`, which feeds the VGA generator's reset input.
- Also drives a parametrised LED distance bar graph.

Parameters:
- CLK_MHZ, 50, clock frequency in MHz; ms tick = CLK_MHZ*1000 cycles.
- PERIOD_PING_MS, 60, ping period in ms.
- DIST_W, 21, width of distance_raw.
- UNITS_PER_CM, 2900, distance_raw counts per cm.
- NEAR_CM, 50, sample is "near" if distance_raw < NEAR_CM*UNITS_PER_CM.
- FAR_CM, 60, sample is "far" if distance_raw >= FAR_CM*UNITS_PER_CM or timeout; must be >= NEAR_CM.
- CONFIRM_N, 3, consecutive same-class samples needed to confirm near/far.
- HOLD_MS, 10000, confirmed-near time before blanking.
- RELEASE_MS, 2000, confirmed-far time before unblanking.
- LED_N, 8, bar-graph width.
- LED_STEP_CM, 5, cm per LED step.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  out  1  one-cycle ping strobe to the ultrasonic block.
- new_measure  in  1  one-cycle valid strobe for distance_raw.
- timeout  in  1  one-cycle strobe: no echo (treated as far).
- distance_raw  in  DIST_W  echo width in clock counts.
- blank  out  1  screen blank request (drives the VGA reset).
- state  out  2  current FSM state encoding.
- led  out  LED_N  distance bar graph.
- fault  out  1  sensor-silent indication (tied 0 unless the optional feature is compiled in).

Behaviour:
- Reset (async) forces all of: start=0, blank=0, state=CLEAR(0), led=0, fault=0, all counters 0.
- Ping: the counter wraps at PERIOD_PING_MS*CLK_MHZ*1000-1. `start`=1 for exactly the cycle the counter equals that value. The first strobe comes one full period after reset release.
- ms tick: a prescaler pulses one cycle every CLK_MHZ*1000 cycles. It free-runs from reset.
- Sample classification happens on a cycle with new_measure=1 or timeout=1:
  - If timeout=1, the sample is far, regardless of new_measure in the same cycle.
  - Otherwise the sample is near, far, or band (NEAR..FAR hysteresis band).
- Confirmation counters near_cnt and far_cnt, each saturating at CONFIRM_N:
  - Near sample: near_cnt++ and far_cnt=0.
  - Far sample: far_cnt++ and near_cnt=0.
  - Band sample: both counters cleared.
- near_ok = (near_cnt==CONFIRM_N); far_ok = (far_cnt==CONFIRM_N).
- FSM states: CLEAR=0, PENDING=1, BLANKED=2, RELEASING=3.
  - CLEAR (blank=0): on near_ok go to PENDING and clear ms_cnt.
  - PENDING (blank=0):
    - ms_cnt increments on ms tick.
    - far_ok goes to CLEAR.
    - ms_cnt reaching HOLD_MS goes to BLANKED.
    - If far_ok and the hold limit occur in the same cycle, far_ok wins.
  - BLANKED (blank=1): on far_ok go to RELEASING and clear ms_cnt.
  - RELEASING (blank=1):
    - ms_cnt increments on ms tick.
    - near_ok goes to BLANKED.
    - ms_cnt reaching RELEASE_MS goes to CLEAR.
    - If both occur in the same cycle, near_ok wins (fail toward blanking).
- Timing: `blank` is registered and changes on the clock edge after the transition condition.
- Confirmation counters keep running across state changes; they are not cleared on transition.
- Width rules:
  - ms_cnt is $clog2(max(HOLD_MS,RELEASE_MS)+1) bits.
  - Threshold products are computed at elaboration, width-extended to DIST_W+1 bits.
  - Comparisons are unsigned.
- LEDs: on a new_measure-only sample, led[i] = (distance_raw > (i+1)*LED_STEP_CM*UNITS_PER_CM). On a timeout sample, led = all ones. Otherwise led holds its value.
- Reset mid-operation returns to CLEAR immediately with blank=0. The ping counter restarts from 0.

Optional Feature:
- Macro: PROXIMITY_GUARD_FAILSAFE_EN.
- When defined:
  - A watchdog counts ms ticks since the last new_measure or timeout.
  - At 4*PERIOD_PING_MS it sets fault=1 and forces the FSM to BLANKED (blank=1).
  - The next sample of any class clears the watchdog and fault. The FSM then continues from BLANKED under the normal rules.
- When undefined: no watchdog logic, fault is tied to 0.

Test Plan (sim params CLK_MHZ=1, PERIOD_PING_MS=1, CONFIRM_N=3, HOLD_MS=20, RELEASE_MS=5, NEAR_CM=50, FAR_CM=60, UNITS_PER_CM=2900):
- Ping: free run 5000 cycles -> start pulses at cycles 999, 1999, 2999, 3999, 4999, each one cycle wide.
- Hold: feed distance_raw=29000 (10 cm) every ping -> PENDING after the 3rd sample; blank=1 once 20 ms ticks have elapsed in PENDING; led=8'b00000001.
- Hysteresis: in BLANKED, feed 159500 (55 cm) indefinitely -> stays BLANKED. Then feed 3 timeouts -> RELEASING, then CLEAR after 5 ms ticks, blank=0, led=8'hFF.
- Debounce: in CLEAR, feed near, near, band (55 cm), near, near -> never leaves CLEAR. Feed near, near, far, then 3 near -> PENDING only after the last of those 3.
- Race: in RELEASING, make the 3rd near sample coincide with the ms tick that reaches RELEASE_MS -> BLANKED, blank never drops. Also assert new_measure and timeout together -> sample classified far.
- Reset: assert reset asynchronously mid-BLANKED -> blank=0, state=0, led=0 without waiting for a clock edge. With PROXIMITY_GUARD_FAILSAFE_EN, stop all samples for 4 ms -> fault=1 and blank=1; one far sample -> fault=0.
